spi_frame_rx: RTL and testbench

Front end of the SPI register path. Oversamples raw SCLK, COPI and nCS pads in the system clock domain. Deserializes 16-bit mode-0 frames, MSB first: bit15 = R/W, bits14:8 = address, bits7:0 = data. Delivers each completed frame as a one-cycle strobe with registered fields to the register file that drives the output-enable, PWM-mode and duty-cycle registers. Incomplete or over-long frames raise a one-cycle error strobe.

---
 rtl/spi_frame_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 42 ++++
 rtl/spi_frame_rx.sv | 134 +++++++++++++
 tb/tb_spi_frame_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants and FSM encoding for the SPI frame receiver.
// Frame layout, MSB first: R/W, address, data.
package spi_frame_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  localparam int unsigned RW_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with a history flop; emits the synchronized level and
// registered single-cycle rise/fall pulses that are time-aligned with that level.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  import spi_frame_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      // Edge pulses update on the same clock as hist_q, so level_o already
      // reflects the new value whenever a pulse is visible.
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI mode-0 frame receiver: deserializes R/W + address + data
// frames and reports each as a one-cycle valid or error strobe.
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = spi_frame_pkg::FRAME_BITS,
  parameter int unsigned ADDR_W      = spi_frame_pkg::ADDR_W,
  parameter int unsigned DATA_W      = spi_frame_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              copi_i,
  input  logic              ncs_i,
  output logic              frame_valid,
  output logic              frame_write,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_error,
  output logic              busy
);

  import spi_frame_pkg::*;

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sclk_rise;
  logic sclk_level_unused;
  logic sclk_fall_unused;
  logic copi_level;
  logic copi_rise_unused;
  logic copi_fall_unused;
  logic ncs_level;
  logic ncs_rise;
  logic ncs_fall;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sclk_i),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall_unused)
  );

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_copi (
    .clk     (clk),
    .rst     (rst),
    .d_i     (copi_i),
    .level_o (copi_level),
    .rise_o  (copi_rise_unused),
    .fall_o  (copi_fall_unused)
  );

  // nCS idles high so a reset never fabricates a chip-select edge.
  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_ncs (
    .clk     (clk),
    .rst     (rst),
    .d_i     (ncs_i),
    .level_o (ncs_level),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  state_t                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_write <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (ncs_fall) begin
            shift_q <= '0;
            count_q <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            busy    <= 1'b0;
            state_q <= DONE;
          end else if (sclk_rise && !ncs_level) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
            // Saturating one past a full frame keeps over-long frames distinct.
            if (count_q != CNT_SAT) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (count_q == CNT_FULL) begin
            frame_valid <= 1'b1;
            frame_write <= shift_q[FRAME_BITS-1];
            frame_addr  <= shift_q[FRAME_BITS-2 -: ADDR_W];
            frame_data  <= shift_q[DATA_W-1:0];
          end else if (count_q != '0) begin
            frame_error <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: table-driven frames plus hand-written
// reset-abort, latency and back-to-back sequences, checked through a scoreboard.
module tb_spi_frame_rx;

  logic       clk;
  logic       rst;
  logic       sclk_i;
  logic       copi_i;
  logic       ncs_i;
  logic       frame_valid;
  logic       frame_write;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_error;
  logic       busy;

  spi_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (sclk_i),
    .copi_i      (copi_i),
    .ncs_i       (ncs_i),
    .frame_valid (frame_valid),
    .frame_write (frame_write),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } exp_t;

  localparam int KValid = 0;
  localparam int KError = 1;
  localparam int KNone  = 2;

  typedef struct {
    logic [31:0] bits;
    int          n;
    int          kind;
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Mode-0 frame at SCLK = clk/8; optional SCLK pulse in the nCS-high gap and
  // optional check of the strobe latency after nCS rises.
  task automatic send_frame(input logic [31:0] bits, input int n, input int gap,
                            input bit toggle, input bit check_lat);
    ncs_i = 1'b0;
    repeat (4) tick();
    check("busy_after_ncs_fall", {31'd0, busy}, 32'd1);
    for (int i = n - 1; i >= 0; i--) begin
      copi_i = bits[i];
      repeat (4) tick();
      sclk_i = 1'b1;
      repeat (4) tick();
      sclk_i = 1'b0;
    end
    repeat (4) tick();
    ncs_i = 1'b1;
    if (toggle) sclk_i = 1'b1;
    for (int t = 1; t <= gap; t++) begin
      tick();
      if (t == 1) sclk_i = 1'b0;
      if (check_lat && t == 4) check("latency_not_early", {31'd0, frame_valid}, 32'd0);
      if (check_lat && t == 5) check("latency_on_time", {31'd0, frame_valid}, 32'd1);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (frame_valid && frame_error) begin
        checks++;
        errors++;
        $display("FAIL strobe_exclusive: valid=1 error=1 required not both");
      end
      if (frame_valid || frame_error) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: valid=%0b error=%0b required none",
                   frame_valid, frame_error);
        end else begin
          e = sb.pop_front();
          check("strobe_kind_is_err", {31'd0, frame_error}, {31'd0, e.is_err});
          check("frame_write", {31'd0, frame_write}, {31'd0, e.w});
          check("frame_addr", {25'd0, frame_addr}, {25'd0, e.a});
          check("frame_data", {24'd0, frame_data}, {24'd0, e.d});
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    sclk_i = 1'b0;
    copi_i = 1'b0;
    ncs_i  = 1'b1;

    vecs[0] = '{32'h84A5,  16, KValid, 1'b1, 7'h04, 8'hA5};
    vecs[1] = '{32'h1300,  16, KValid, 1'b0, 7'h13, 8'h00};
    vecs[2] = '{32'h7FFF,  16, KValid, 1'b0, 7'h7F, 8'hFF};
    vecs[3] = '{32'h8000,  16, KValid, 1'b1, 7'h00, 8'h00};
    vecs[4] = '{32'h84A5,  16, KValid, 1'b1, 7'h04, 8'hA5};
    vecs[5] = '{32'h00FF,   8, KError, 1'b1, 7'h04, 8'hA5};
    vecs[6] = '{32'h1FFFF, 17, KError, 1'b1, 7'h04, 8'hA5};
    vecs[7] = '{32'h0,      0, KNone,  1'b1, 7'h04, 8'hA5};
    vecs[8] = '{32'h1,      1, KError, 1'b1, 7'h04, 8'hA5};

    repeat (3) tick();
    check("reset_valid", {31'd0, frame_valid}, 32'd0);
    check("reset_error", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_fields", {16'd0, frame_write, frame_addr, frame_data}, 32'd0);
    rst = 1'b0;
    repeat (6) tick();

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].kind != KNone) begin
        sb.push_back('{vecs[v].kind == KError, vecs[v].w, vecs[v].a, vecs[v].d});
      end
      send_frame(vecs[v].bits, vecs[v].n, 8, 1'b0, v == 0);
      repeat (4) tick();
      check("busy_idle_after_frame", {31'd0, busy}, 32'd0);
    end

    // Abort mid-frame with reset; nothing may be reported for the partial frame.
    ncs_i = 1'b0;
    repeat (4) tick();
    for (int i = 15; i >= 6; i--) begin
      copi_i = i[0];
      repeat (4) tick();
      sclk_i = 1'b1;
      repeat (4) tick();
      sclk_i = 1'b0;
    end
    rst    = 1'b1;
    ncs_i  = 1'b1;
    repeat (3) tick();
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_fields", {16'd0, frame_write, frame_addr, frame_data}, 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    sb.push_back('{1'b0, 1'b1, 7'h0A, 8'h3C});
    send_frame(32'h8A3C, 16, 8, 1'b0, 1'b0);

    // Back-to-back frames with a 2-clk gap and SCLK pulsing while deselected.
    sb.push_back('{1'b0, 1'b1, 7'h01, 8'h11});
    sb.push_back('{1'b0, 1'b1, 7'h02, 8'h22});
    send_frame(32'h8111, 16, 2, 1'b1, 1'b0);
    send_frame(32'h8222, 16, 8, 1'b0, 1'b0);

    for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
    repeat (10) tick();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
